// File: rtl/sprite_rom_reader_pkg.sv
// Shared types for the sprite read path: FSM states, screen limits, colour width
// and the coordinate beat that travels alongside each ROM read.
package sprite_rom_reader_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOR_W  = 3;

  // Sums are one bit wider than the screen coordinates so off-screen pixels clip instead of wrapping.
  typedef struct packed {
    logic       vld;
    logic [8:0] x9;
    logic [7:0] y8;
  } beat_t;

endpackage

// File: rtl/sprite_delay_line.sv
// Holds each issued coordinate beat for DEPTH cycles so it meets the ROM's returned colour.
// Latency DEPTH cycles; no backpressure, shifts every cycle.
module sprite_delay_line
  import sprite_rom_reader_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  resetn,
  input  beat_t entry,
  output beat_t delayed
);

  beat_t stage [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= entry;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/sprite_rom_reader.sv
// Walks a sprite rectangle, reads its colours from a synchronous ROM and emits aligned plot beats.
// First plot ROM_LAT+1 cycles after start is accepted; one beat per cycle, no backpressure.
module sprite_rom_reader #(
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  parameter int ADDR_W   = 11,
  parameter int ROM_LAT  = 1,
  parameter int SCREEN_W = sprite_rom_reader_pkg::SCREEN_W,
  parameter int SCREEN_H = sprite_rom_reader_pkg::SCREEN_H
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     start,
  input  logic [7:0]                               xOrigin,
  input  logic [6:0]                               yOrigin,
  output logic [ADDR_W-1:0]                        romAddr,
  input  logic [sprite_rom_reader_pkg::COLOR_W-1:0] romData,
  output logic [7:0]                               x,
  output logic [6:0]                               y,
  output logic [sprite_rom_reader_pkg::COLOR_W-1:0] color,
  output logic                                     plot,
  output logic                                     busy,
  output logic                                     done
);
  import sprite_rom_reader_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(SPRITE_W * SPRITE_H - 1);
  localparam logic [7:0]        COL_LAST   = 8'(SPRITE_W - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(ROM_LAT);
  localparam logic [8:0]        X_LIMIT    = 9'(SCREEN_W);
  localparam logic [7:0]        Y_LIMIT    = 8'(SCREEN_H);

  state_t     state, stateNext;
  logic [7:0] xOrg, col;
  logic [6:0] yOrg, row;
  logic [1:0] drainCnt;
  beat_t      issue, delayed;

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) stateNext = READ;
      READ: begin
        busy = 1'b1;
        if (romAddr == ADDR_LAST) stateNext = DRAIN;
      end
      // One extra drain cycle so done lands the cycle after the last plot beat.
      DRAIN: begin
        busy = 1'b1;
        if (drainCnt == DRAIN_LAST) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      romAddr  <= '0;
      col      <= '0;
      row      <= '0;
      xOrg     <= '0;
      yOrg     <= '0;
      drainCnt <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: if (start) begin
          xOrg    <= xOrigin;
          yOrg    <= yOrigin;
          col     <= '0;
          row     <= '0;
          romAddr <= '0;
        end
        READ: begin
          drainCnt <= '0;
          if (romAddr != ADDR_LAST) begin
            romAddr <= romAddr + 1'b1;
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 7'd1;
            end else begin
              col <= col + 8'd1;
            end
          end
        end
        DRAIN:   drainCnt <= drainCnt + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    issue     = '0;
    issue.vld = (state == READ);
    issue.x9  = {1'b0, xOrg} + {1'b0, col};
    issue.y8  = {1'b0, yOrg} + {1'b0, row};
  end

  sprite_delay_line #(.DEPTH(ROM_LAT)) uDelay (
    .clk     (clk),
    .resetn  (resetn),
    .entry   (issue),
    .delayed (delayed)
  );

  // Clipped beats still move x/y/color; only the write strobe is suppressed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x     <= '0;
      y     <= '0;
      color <= '0;
      plot  <= 1'b0;
    end else begin
      plot <= delayed.vld && (delayed.x9 < X_LIMIT) && (delayed.y8 < Y_LIMIT);
      if (delayed.vld) begin
        x     <= delayed.x9[7:0];
        y     <= delayed.y8[6:0];
        color <= romData;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_reader.sv
// Bench for sprite_rom_reader: a 40x40/latency-1 instance and a 4x4/latency-2 instance,
// each fed by a behavioural ROM and checked cycle by cycle against a pixel-index model.
module tb_sprite_rom_reader;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color;
    logic [10:0] addr;
  } obs_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start1, start2;
  logic [7:0]  xo1, xo2, x1, x2;
  logic [6:0]  yo1, yo2, y1, y2;
  logic [10:0] romAddr1;
  logic [3:0]  romAddr2;
  logic [2:0]  romData1, romData2, rom2q, color1, color2;
  logic        plot1, plot2, busy1, busy2, done1, done2;

  logic [2:0]  rom1 [2048];
  logic [2:0]  rom2 [16];

  int vectors = 0;
  int miscompares = 0;
  int mX [2];
  int mY [2];
  int mC [2];

  always #5 clk = ~clk;

  always @(posedge clk) romData1 <= rom1[romAddr1];
  always @(posedge clk) begin
    rom2q    <= rom2[romAddr2];
    romData2 <= rom2q;
  end

  sprite_rom_reader #(.SPRITE_W(40), .SPRITE_H(40), .ADDR_W(11), .ROM_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .xOrigin(xo1), .yOrigin(yo1),
    .romAddr(romAddr1), .romData(romData1), .x(x1), .y(y1), .color(color1),
    .plot(plot1), .busy(busy1), .done(done1)
  );

  sprite_rom_reader #(.SPRITE_W(4), .SPRITE_H(4), .ADDR_W(4), .ROM_LAT(2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .xOrigin(xo2), .yOrigin(yo2),
    .romAddr(romAddr2), .romData(romData2), .x(x2), .y(y2), .color(color2),
    .plot(plot2), .busy(busy2), .done(done2)
  );

  function automatic int sideOf(int d);
    return (d == 0) ? 40 : 4;
  endfunction

  function automatic int latOf(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic obs_t sample(int d);
    obs_t o;
    if (d == 0) begin
      o.busy = busy1; o.done = done1; o.plot = plot1;
      o.x = x1; o.y = y1; o.color = color1; o.addr = romAddr1;
    end else begin
      o.busy = busy2; o.done = done2; o.plot = plot2;
      o.x = x2; o.y = y2; o.color = color2; o.addr = 11'(romAddr2);
    end
    return o;
  endfunction

  // Expected outputs c cycles after the accepting clock edge: pixel i=c-L-1 appears in row-major order.
  task automatic model(input int d, input int c, input int xo, input int yo, output obs_t e);
    int w, lat, n, i, xs, ys;
    w   = sideOf(d);
    lat = latOf(d);
    n   = w * w;
    e.busy = (c <= n + lat);
    e.done = (c == n + lat + 1);
    e.addr = 11'((c < n) ? c : n - 1);
    e.plot = 1'b0;
    i = c - lat - 1;
    if (i >= 0 && i < n) begin
      xs = xo + i % w;
      ys = yo + i / w;
      mX[d] = xs % 256;
      mY[d] = ys % 128;
      mC[d] = (d == 0) ? int'(rom1[i]) : int'(rom2[i]);
      e.plot = (xs < 160) && (ys < 120);
    end
    e.x     = 8'(mX[d]);
    e.y     = 7'(mY[d]);
    e.color = 3'(mC[d]);
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      mX[d] = 0; mY[d] = 0; mC[d] = 0;
    end
  endtask

  task automatic start_draw(input int d, input int xo, input int yo);
    @(negedge clk);
    if (d == 0) begin start1 = 1'b1; xo1 = 8'(xo); yo1 = 7'(yo); end
    else        begin start2 = 1'b1; xo2 = 8'(xo); yo2 = 7'(yo); end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic fill_rom(input int d, input bit modPattern);
    if (d == 0) for (int a = 0; a < 2048; a++) rom1[a] = modPattern ? 3'(a % 8) : 3'($urandom_range(7));
    else        for (int a = 0; a < 16; a++)   rom2[a] = modPattern ? 3'(a % 8) : 3'($urandom_range(7));
  endtask

  task automatic test_reset();
    obs_t got;
    resetn = 1'b0; start1 = 1'b0; start2 = 1'b0;
    xo1 = '0; yo1 = '0; xo2 = '0; yo2 = '0;
    clear_model();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      got = sample(d);
      vectors++;
      if (got !== '0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d got=%p required all zero", d, got);
      end
    end
    resetn = 1'b1;
    @(negedge clk);
    got = sample(0);
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL idle_after_reset got=%p required all zero", got);
    end
  endtask

  task automatic test_basic();
    obs_t got, exp;
    int firstPlot = -1;
    fill_rom(0, 1'b1);
    start_draw(0, 36, 30);
    for (int c = 0; c <= 1600 + 4; c++) begin
      @(negedge clk);
      model(0, c, 36, 30, exp);
      got = sample(0);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL basic c=%0d got=%p exp=%p", c, got, exp);
      end
      if (got.plot && firstPlot < 0) firstPlot = c;
    end
    vectors++;
    if (firstPlot != 2) begin
      miscompares++;
      $display("FAIL first_plot_latency got=%0d required=2", firstPlot);
    end
    vectors++;
    if ({x1, y1, color1} !== {8'd75, 7'd69, 3'd7}) begin
      miscompares++;
      $display("FAIL last_pixel got=(%0d,%0d,%0d) required=(75,69,7)", x1, y1, color1);
    end
  endtask

  task automatic test_clip();
    obs_t got, exp;
    int plots = 0;
    int busyCycles = 0;
    fill_rom(0, 1'b0);
    start_draw(0, 150, 100);
    for (int c = 0; c <= 1600 + 4; c++) begin
      @(negedge clk);
      model(0, c, 150, 100, exp);
      got = sample(0);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL clip c=%0d got=%p exp=%p", c, got, exp);
      end
      if (got.plot) plots++;
      if (got.busy) busyCycles++;
    end
    vectors++;
    if (plots != 200) begin
      miscompares++;
      $display("FAIL clip_plot_count got=%0d required=200", plots);
    end
    vectors++;
    if (busyCycles != 1602) begin
      miscompares++;
      $display("FAIL clip_busy_cycles got=%0d required=1602", busyCycles);
    end
  endtask

  task automatic test_random();
    obs_t got, exp;
    int xo, yo;
    for (int k = 0; k < 2; k++) begin
      fill_rom(0, 1'b0);
      xo = int'($urandom_range(255));
      yo = int'($urandom_range(127));
      start_draw(0, xo, yo);
      for (int c = 0; c <= 1600 + 3; c++) begin
        @(negedge clk);
        model(0, c, xo, yo, exp);
        got = sample(0);
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL random k=%0d origin=(%0d,%0d) c=%0d got=%p exp=%p", k, xo, yo, c, got, exp);
        end
        xo1 = 8'($urandom_range(255));
        yo1 = 7'($urandom_range(127));
      end
    end
  endtask

  task automatic test_start_ignored();
    obs_t got, exp;
    int dones = 0;
    fill_rom(0, 1'b0);
    start_draw(0, 36, 30);
    for (int c = 0; c <= 1600 + 8; c++) begin
      @(negedge clk);
      model(0, c, 36, 30, exp);
      got = sample(0);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL start_ignored c=%0d got=%p exp=%p", c, got, exp);
      end
      if (got.done) dones++;
      if (c == 502) begin start1 = 1'b1; xo1 = '0; yo1 = '0; end
      if (c == 503) start1 = 1'b0;
      if (c == 1602) start1 = 1'b1;
      if (c == 1603) start1 = 1'b0;
    end
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL single_done got=%0d required=1", dones);
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    fill_rom(0, 1'b0);
    start_draw(0, 36, 30);
    for (int c = 0; c <= 802; c++) begin
      @(negedge clk);
      model(0, c, 36, 30, exp);
      got = sample(0);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL pre_reset c=%0d got=%p exp=%p", c, got, exp);
      end
    end
    #1 resetn = 1'b0;
    #1 got = sample(0);
    clear_model();
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL async_reset got=%p required all zero", got);
    end
    @(negedge clk);
    resetn = 1'b1;
    start_draw(0, 0, 0);
    for (int c = 0; c <= 1600 + 3; c++) begin
      @(negedge clk);
      model(0, c, 0, 0, exp);
      got = sample(0);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL post_reset c=%0d got=%p exp=%p", c, got, exp);
      end
    end
  endtask

  task automatic test_lat2();
    obs_t got, exp;
    int firstPlot;
    int xo, yo;
    for (int k = 0; k < 3; k++) begin
      fill_rom(1, 1'b0);
      xo = (k == 0) ? 0 : int'($urandom_range(255));
      yo = (k == 0) ? 0 : int'($urandom_range(127));
      firstPlot = -1;
      start_draw(1, xo, yo);
      for (int c = 0; c <= 16 + 5; c++) begin
        @(negedge clk);
        model(1, c, xo, yo, exp);
        got = sample(1);
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL lat2 k=%0d origin=(%0d,%0d) c=%0d got=%p exp=%p", k, xo, yo, c, got, exp);
        end
        if (got.plot && firstPlot < 0) firstPlot = c;
      end
      if (k == 0) begin
        vectors++;
        if (firstPlot != 3) begin
          miscompares++;
          $display("FAIL lat2_first_plot got=%0d required=3", firstPlot);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    int plots = 0;
    int dones = 0;
    int xo, yo;
    localparam int P = 16 + 2 + 3;
    fill_rom(1, 1'b0);
    xo = int'($urandom_range(156));
    yo = int'($urandom_range(116));
    @(negedge clk);
    start2 = 1'b1; xo2 = 8'(xo); yo2 = 7'(yo);
    @(posedge clk);
    for (int c = 0; c < 3 * P; c++) begin
      @(negedge clk);
      model(1, c % P, xo, yo, exp);
      got = sample(1);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL back_to_back c=%0d got=%p exp=%p", c, got, exp);
      end
      if (got.plot) plots++;
      if (got.done) dones++;
    end
    start2 = 1'b0;
    vectors++;
    if (plots != 48 || dones != 3) begin
      miscompares++;
      $display("FAIL back_to_back_counts got plots=%0d dones=%0d required plots=48 dones=3", plots, dones);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_lat2();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
